// File: rtl/axi_spy_pkg.sv
// axi_spy_pkg: shared channel indices, channel count and FSM state type for the spy drain arbiter
package axi_spy_pkg;
    localparam int NUM_CH = 4;
    typedef enum logic [1:0] {CH_AR, CH_AW, CH_R, CH_W} ch_e;
    typedef enum logic [1:0] {IDLE, BUSY, STALL} state_e;
endpackage

// File: rtl/axi_spy_rr_pick.sv
// axi_spy_rr_pick: round-robin picker, search starts one past ptr and returns a one-hot grant
//   req   in  4  request vector
//   ptr   in  2  index granted last time
//   gnt   out 4  one-hot grant (zero when no request)
//   valid out 1  any request present
module axi_spy_rr_pick
    import axi_spy_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [1:0]        ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic              valid
);
    logic [1:0] idx;
    assign valid = |req;
    // Walk from the farthest candidate back to the nearest so the nearest request wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = ptr + 2'(i);
            gnt = req[idx] ? NUM_CH'(1) << idx : gnt;
        end
    end
endmodule

// File: rtl/axi_spy_drain_arb.sv
// axi_spy_drain_arb: drains four AXI spy FIFOs into one trace stream with urgency-tiered round-robin
//   clk, rst_n            clock, async active-low reset
//   drain_en              allow new grants
//   ch_valid/ch_full      per-channel FIFO non-empty / full (0=AR 1=AW 2=R 3=W)
//   ch_data               per-channel FIFO head
//   ch_pop                combinational one-hot pop of the granted head
//   out_valid/out_ready   trace stream handshake
//   out_data/out_chan     captured entry and its source channel
//   out_ts                capture timestamp (zero unless AXI_SPY_DRAIN_TS_EN is defined)
//   grant_cnt             per-channel saturating pop counters
// Optional feature macro: AXI_SPY_DRAIN_TS_EN enables the free-running timestamp counter.
module axi_spy_drain_arb
    import axi_spy_pkg::*;
#(
    parameter int ENTRY_WIDTH = 64,
    parameter int TS_WIDTH    = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               drain_en,
    input  logic [NUM_CH-1:0]                  ch_valid,
    input  logic [NUM_CH-1:0]                  ch_full,
    input  logic [NUM_CH-1:0][ENTRY_WIDTH-1:0] ch_data,
    output logic [NUM_CH-1:0]                  ch_pop,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ENTRY_WIDTH-1:0]             out_data,
    output logic [1:0]                         out_chan,
    output logic [TS_WIDTH-1:0]                out_ts,
    output logic [NUM_CH-1:0][15:0]            grant_cnt
);
    state_e                      state_q, state_d;
    logic [1:0]                  last_grant_q, last_grant_d;
    logic [ENTRY_WIDTH-1:0]      out_data_q, out_data_d;
    logic [1:0]                  out_chan_q, out_chan_d;
    logic [NUM_CH-1:0][15:0]     grant_cnt_q, grant_cnt_d;
    logic [NUM_CH-1:0]           urgent, req, gnt;
    logic [1:0]                  gidx;
    logic                        pick_valid, loadable, grant;

    assign urgent   = ch_valid & ch_full;
    assign req      = |urgent ? urgent : ch_valid;
    assign loadable = state_q == IDLE || out_ready;
    // rst_n gates the grant so nothing is popped while reset is held.
    assign grant    = rst_n && loadable && drain_en && pick_valid;
    assign gidx     = {gnt[3] | gnt[2], gnt[3] | gnt[1]};

    axi_spy_rr_pick u_pick (
        .req   (req),
        .ptr   (last_grant_q),
        .gnt   (gnt),
        .valid (pick_valid)
    );

    always_comb begin
        ch_pop       = grant ? gnt : '0;
        state_d      = grant ? BUSY : (state_q != IDLE && !out_ready) ? STALL : IDLE;
        last_grant_d = grant ? gidx : last_grant_q;
        out_data_d   = grant ? ch_data[gidx] : out_data_q;
        out_chan_d   = grant ? gidx : out_chan_q;
        for (int i = 0; i < NUM_CH; i++)
            grant_cnt_d[i] = grant_cnt_q[i] + 16'(ch_pop[i] && grant_cnt_q[i] != 16'hFFFF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 2'd3;
            out_data_q   <= '0;
            out_chan_q   <= '0;
            grant_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            out_data_q   <= out_data_d;
            out_chan_q   <= out_chan_d;
            grant_cnt_q  <= grant_cnt_d;
        end
    end

    assign out_valid = state_q != IDLE;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign grant_cnt = grant_cnt_q;

`ifdef AXI_SPY_DRAIN_TS_EN
    logic [TS_WIDTH-1:0] ts_q, ts_d, out_ts_q, out_ts_d;
    assign ts_d     = ts_q + TS_WIDTH'(1);
    assign out_ts_d = grant ? ts_q : out_ts_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q     <= '0;
            out_ts_q <= '0;
        end else begin
            ts_q     <= ts_d;
            out_ts_q <= out_ts_d;
        end
    end
    assign out_ts = out_ts_q;
`else
    assign out_ts = '0;
`endif
endmodule

// File: tb/tb_axi_spy_drain_arb.sv
// tb_axi_spy_drain_arb: randomized bench against a behavioural model of the spy drain arbiter
module tb_axi_spy_drain_arb;
    logic             clk = 0;
    logic             rst_n = 0;
    logic             drain_en = 0;
    logic [3:0]       ch_valid = 0;
    logic [3:0]       ch_full = 0;
    logic [3:0][63:0] ch_data = '0;
    logic [3:0]       ch_pop;
    logic             out_valid;
    logic             out_ready = 0;
    logic [63:0]      out_data;
    logic [1:0]       out_chan;
    logic [31:0]      out_ts;
    logic [3:0][15:0] grant_cnt;

    axi_spy_drain_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .drain_en  (drain_en),
        .ch_valid  (ch_valid),
        .ch_full   (ch_full),
        .ch_data   (ch_data),
        .ch_pop    (ch_pop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ts    (out_ts),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    bit          m_valid;
    logic [63:0] m_data;
    int          m_chan;
    int          m_last;
    logic [31:0] m_ts;
    logic [31:0] m_out_ts;
    int          m_cnt[4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_chan = 0; m_last = 3; m_ts = 0; m_out_ts = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    function automatic int model_pick();
        logic [3:0] set;
        int g;
        if (!rst_n || !drain_en || ch_valid == 0 || (m_valid && !out_ready)) return -1;
        set = (ch_valid & ch_full) != 0 ? (ch_valid & ch_full) : ch_valid;
        for (int k = 1; k <= 4; k++) begin
            g = (m_last + k) % 4;
            if (set[g]) return g;
        end
        return -1;
    endfunction

    task automatic step();
        int g;
        logic [3:0] p;
        #1;
        g = model_pick();
        p = g < 0 ? 4'd0 : 4'd1 << g;
        chk("ch_pop", ch_pop, p);
        @(posedge clk);
        if (g >= 0) begin
            m_valid = 1; m_data = ch_data[g]; m_chan = g; m_last = g;
`ifdef AXI_SPY_DRAIN_TS_EN
            m_out_ts = m_ts;
`endif
            if (m_cnt[g] < 65535) m_cnt[g]++;
        end else if (out_ready) m_valid = 0;
        m_ts++;
        @(negedge clk);
        chk("out_valid", out_valid, m_valid);
        chk("out_chan", out_chan, m_chan);
        chk("out_data", out_data, m_data);
        chk("out_ts", out_ts, m_out_ts);
        for (int i = 0; i < 4; i++) chk($sformatf("grant_cnt%0d", i), grant_cnt[i], m_cnt[i]);
    endtask

    task automatic do_reset();
        rst_n = 0; ch_valid = 4'hF; drain_en = 1; out_ready = 1;
        #1;
        chk("rst_pop", ch_pop, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_chan", out_chan, 0);
        chk("rst_ts", out_ts, 0);
        chk("rst_cnt", grant_cnt, 0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_pop_hold", ch_pop, 0);
        model_reset();
        rst_n = 1;
    endtask

    task automatic rand_data();
        for (int c = 0; c < 4; c++) ch_data[c] = {$urandom, $urandom};
    endtask

    logic [31:0] t1;

    initial begin
        @(negedge clk);
        do_reset();
        // timestamp spacing: two grants three cycles apart
        ch_valid = 0;
        repeat (9) step();
        rand_data(); ch_valid = 4'b0001; step();
        t1 = out_ts;
        ch_valid = 0; step(); step();
        rand_data(); ch_valid = 4'b0001; step();
`ifdef AXI_SPY_DRAIN_TS_EN
        chk("ts_diff", out_ts - t1, 3);
`else
        chk("ts_zero", out_ts | t1, 0);
`endif
        @(negedge clk);
        do_reset();
        ch_valid = 4'hF; ch_full = 0; drain_en = 1; out_ready = 1;
        for (int k = 0; k < 5; k++) begin
            rand_data(); step();
            chk($sformatf("rr_order%0d", k), out_chan, k % 4);
        end
        ch_full = 4'b0100; rand_data(); step();
        chk("urgent_r", out_chan, 2);
        ch_full = 0; out_ready = 0;
        for (int k = 0; k < 5; k++) begin
            rand_data(); step();
            chk("bp_pop", ch_pop, 0);
            chk("bp_valid", out_valid, 1);
        end
        out_ready = 1; rand_data(); step();
        chk("bp_release_chan", out_chan, 3);
        out_ready = 0; step();
        drain_en = 0; step();
        out_ready = 1; step();
        chk("drain_done", out_valid, 0);
        repeat (2) begin
            rand_data(); step();
            chk("drain_pop", ch_pop, 0);
        end
        for (int n = 0; n < 3000; n++) begin
            ch_valid = 4'($urandom);
            ch_full = 4'($urandom & $urandom);
            drain_en = $urandom_range(0, 7) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            rand_data();
            if ($urandom_range(0, 199) == 0) do_reset();
            else step();
        end
        do_reset();
        ch_valid = 4'b1000; ch_full = 0; drain_en = 1; out_ready = 1;
        repeat (65540) step();
        chk("cnt_sat", grant_cnt[3], 16'hFFFF);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
